// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master and its helpers.
package apb_pkg;

  localparam int unsigned DEF_ADDR_W  = 3;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with pready low and flags the last cycle before abort.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Wait counter: cleared per transfer, saturates at TIMEOUT so it never wraps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt < CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Current ACCESS cycle is the TIMEOUT-th one
  assign o_expired_c = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready command in, APB transfer, response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_mst_state_e r_state;
  apb_mst_state_e w_state_nxt;

  logic              w_accept;
  logic              w_timer_clear;
  logic              w_timer_en;
  logic              w_timer_expired;
  logic              w_rsp_load;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_rsp_err_nxt;
  logic              w_rsp_timeout_nxt;

  logic              r_cmd_ready;
  logic              r_pselx;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk       (pclk),
    .i_rst       (preset),
    .i_clear     (w_timer_clear),
    .i_enable    (w_timer_en),
    .o_expired_c (w_timer_expired)
  );

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer-control decode
  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_timer_clear     = 1'b0;
    w_timer_en        = 1'b0;
    w_rsp_load        = 1'b0;
    w_rsp_rdata_nxt   = '0;
    w_rsp_err_nxt     = 1'b0;
    w_rsp_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_timer_clear = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          w_rsp_load      = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          w_rsp_err_nxt   = pslverr;
          w_state_nxt     = RESP;
        end else if (w_timer_expired) begin
          w_rsp_load        = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_state_nxt       = RESP;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state; bus/response fields load on events
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cmd_ready   <= 1'b1;
      r_pselx       <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_pselx     <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
      r_penable   <= (w_state_nxt == ACCESS);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_rsp_load) begin
        r_rsp_rdata   <= w_rsp_rdata_nxt;
        r_rsp_err     <= w_rsp_err_nxt;
        r_rsp_timeout <= w_rsp_timeout_nxt;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign pselx       = r_pselx;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a transfer-timeline model checked every cycle.
module tb_apb_master;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  apb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  always #5 pclk = ~pclk;

  // Timeline model: a transfer accepted at edge p_acc occupies the bus for 1 + p_a cycles,
  // then presents its response for 1 + p_d cycles.
  int            cyc = 0;
  int            p_acc, p_a, p_d;
  bit            p_to;
  logic          cur_wr, prv_wr;
  logic [AW-1:0] cur_addr, prv_addr;
  logic [DW-1:0] cur_wd, prv_wd;
  logic [DW-1:0] cur_rdata, prv_rdata;
  logic          cur_err, prv_err, cur_tmo, prv_tmo;
  bit            chk_en = 1'b0;
  int            pen_total = 0;
  int            pen_base = 0;
  int            n_pass = 0;
  int            n_chk = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void model_reset();
    p_acc = -1000; p_a = 1; p_d = 0; p_to = 1'b0;
    cur_wr = 1'b0; prv_wr = 1'b0; cur_addr = '0; prv_addr = '0;
    cur_wd = '0; prv_wd = '0; cur_rdata = '0; prv_rdata = '0;
    cur_err = 1'b0; prv_err = 1'b0; cur_tmo = 1'b0; prv_tmo = 1'b0;
  endfunction

  function automatic void compare_all();
    int c;
    bit e_sel, e_en, e_rv, e_cr, rn, bn;
    c     = cyc;
    e_sel = (c >= p_acc) && (c <= p_acc + p_a);
    e_en  = (c >= p_acc + 1) && (c <= p_acc + p_a);
    e_rv  = (c >= p_acc + p_a + 1) && (c <= p_acc + p_a + 1 + p_d);
    e_cr  = (c < p_acc) || (c >= p_acc + p_a + 2 + p_d);
    rn    = (c >= p_acc + p_a + 1);
    bn    = (c >= p_acc);
    chk("cmd_ready",   32'(cmd_ready),   32'(e_cr));
    chk("pselx",       32'(pselx),       32'(e_sel));
    chk("penable",     32'(penable),     32'(e_en));
    chk("rsp_valid",   32'(rsp_valid),   32'(e_rv));
    chk("pwrite",      32'(pwrite),      32'(bn ? cur_wr : prv_wr));
    chk("paddr",       32'(paddr),       32'(bn ? cur_addr : prv_addr));
    chk("pwdata",      32'(pwdata),      32'(bn ? cur_wd : prv_wd));
    chk("rsp_rdata",   32'(rsp_rdata),   32'(rn ? cur_rdata : prv_rdata));
    chk("rsp_err",     32'(rsp_err),     32'(rn ? cur_err : prv_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(rn ? cur_tmo : prv_tmo));
  endfunction

  // One clock: compare on the falling edge, then advance to 1 time unit past the rising edge
  task automatic step();
    @(negedge pclk);
    if (chk_en) compare_all();
    if (penable === 1'b1) pen_total++;
    @(posedge pclk);
    cyc++;
    #1;
  endtask

  // waits >= TO means pready never rises; rst_k aborts in that ACCESS cycle; lag delays accept
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd, input bit err,
                        input int d, input int rst_k, input int lag);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    for (int i = 0; i < lag; i++) begin
      step();
      rsp_ready = 1'b0;
    end
    prv_wr = cur_wr; prv_addr = cur_addr; prv_wd = cur_wd;
    prv_rdata = cur_rdata; prv_err = cur_err; prv_tmo = cur_tmo;
    cur_wr = wr; cur_addr = a; cur_wd = wd;
    p_to      = (waits >= int'(TO));
    p_a       = p_to ? int'(TO) : waits + 1;
    cur_rdata = (p_to || wr) ? 8'h00 : rd;
    cur_err   = p_to || err;
    cur_tmo   = p_to;
    p_d       = d;
    p_acc     = cyc + 1;
    pen_base  = pen_total;
    step();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
    pready = 1'b0; prdata = 8'hEE; pslverr = 1'b1;
    for (int k = 1; k <= p_a; k++) begin
      step();
      if (!p_to && k == waits + 1) begin
        pready = 1'b1; prdata = rd; pslverr = err;
      end else begin
        pready = 1'b0; prdata = 8'hEE; pslverr = 1'b1;
      end
      if (k == rst_k) begin
        preset = 1'b1;
        step();
        preset = 1'b0;
        pready = 1'b0;
        model_reset();
        return;
      end
    end
    step();
    pready = 1'b0; prdata = 8'hEE; pslverr = 1'b1;
    rsp_ready = (d == 0);
    for (int i = 1; i <= d; i++) begin
      step();
      if (i == d) rsp_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    step();
    step();
    preset = 1'b0;
    chk_en = 1'b1;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset pselx",     32'(pselx),     32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    idle(2);

    // Write, zero wait states
    do_txn(1'b1, 3'd3, 8'hA5, 0, 8'h00, 1'b0, 0, 0, 0);
    chk("wr0 penable cycles", 32'(pen_total - pen_base), 32'd1);
    chk("wr0 paddr",  32'(paddr),  32'd3);
    chk("wr0 pwdata", 32'(pwdata), 32'hA5);
    chk("wr0 pwrite", 32'(pwrite), 32'd1);
    chk("wr0 rdata",  32'(rsp_rdata), 32'h00);
    chk("wr0 err",    32'(rsp_err), 32'd0);
    idle(2);

    // Read, two wait states
    do_txn(1'b0, 3'd5, 8'h00, 2, 8'h3C, 1'b0, 0, 0, 0);
    chk("rd2 penable cycles", 32'(pen_total - pen_base), 32'd3);
    chk("rd2 rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd2 err",   32'(rsp_err), 32'd0);
    idle(1);

    // Slave error
    do_txn(1'b0, 3'd7, 8'h00, 0, 8'hFF, 1'b1, 0, 0, 0);
    chk("slverr err",     32'(rsp_err), 32'd1);
    chk("slverr timeout", 32'(rsp_timeout), 32'd0);
    chk("slverr rdata",   32'(rsp_rdata), 32'hFF);
    idle(1);

    // Timeout with pready held low
    do_txn(1'b0, 3'd1, 8'h00, 40, 8'h99, 1'b0, 0, 0, 0);
    chk("tmo penable cycles", 32'(pen_total - pen_base), 32'd15);
    chk("tmo pselx",   32'(pselx), 32'd0);
    chk("tmo err",     32'(rsp_err), 32'd1);
    chk("tmo timeout", 32'(rsp_timeout), 32'd1);
    chk("tmo rdata",   32'(rsp_rdata), 32'h00);
    idle(1);

    // pready rises in the 15th ACCESS cycle
    do_txn(1'b0, 3'd6, 8'h00, 14, 8'h5A, 1'b0, 0, 0, 0);
    chk("late penable cycles", 32'(pen_total - pen_base), 32'd15);
    chk("late timeout", 32'(rsp_timeout), 32'd0);
    chk("late rdata",   32'(rsp_rdata), 32'h5A);
    idle(1);

    // Backpressure then back-to-back accept
    do_txn(1'b1, 3'd2, 8'h11, 1, 8'h00, 1'b0, 5, 0, 0);
    chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp paddr",     32'(paddr), 32'd2);
    do_txn(1'b0, 3'd6, 8'h00, 0, 8'h77, 1'b0, 0, 0, 1);
    chk("b2b penable cycles", 32'(pen_total - pen_base), 32'd1);
    chk("b2b rdata", 32'(rsp_rdata), 32'h77);
    do_txn(1'b1, 3'd0, 8'h42, 0, 8'h00, 1'b0, 0, 0, 1);
    chk("b2b2 rdata", 32'(rsp_rdata), 32'h00);
    idle(1);

    // Reset during the second wait state
    do_txn(1'b0, 3'd4, 8'h00, 5, 8'h81, 1'b0, 0, 2, 0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst pselx",     32'(pselx), 32'd0);
    chk("rst penable",   32'(penable), 32'd0);
    chk("rst paddr",     32'(paddr), 32'd0);
    chk("rst rdata",     32'(rsp_rdata), 32'h00);
    idle(1);

    // Normal write after reset
    do_txn(1'b1, 3'd1, 8'hC3, 0, 8'h00, 1'b0, 0, 0, 0);
    chk("post penable cycles", 32'(pen_total - pen_base), 32'd1);
    chk("post pwdata", 32'(pwdata), 32'hC3);
    chk("post err",    32'(rsp_err), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
